// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator key sequencer.
//   - state_t   : sequencer state encoding (also exported on the debug port)
//   - KEY_*     : decoded key codes arriving from the keyboard decoder
//   - DSP_*     : non-digit seven-segment display codes
//   - OP_*      : op_sel encoding understood by the arithmetic datapath
//   - is_digit  : true for key codes 0-9
package calc_pkg;

    typedef enum logic [3:0] {
        ST_A_HI    = 4'd0,
        ST_A_LO    = 4'd1,
        ST_OP      = 4'd2,
        ST_B_HI    = 4'd3,
        ST_B_LO    = 4'd4,
        ST_WAIT_EQ = 4'd5,
        ST_CALC    = 4'd6,
        ST_SHOW    = 4'd7,
        ST_ERR     = 4'd8
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_EQ  = 4'd13;
    localparam logic [3:0] KEY_CLR = 4'd14;

    localparam logic [3:0] DSP_MINUS = 4'd10;
    localparam logic [3:0] DSP_E     = 4'd14;
    localparam logic [3:0] DSP_BLANK = 4'd15;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/calc_disp_map.sv
// calc_disp_map: purely combinational mapping from sequencer state, operand
// registers and latched result to the four seven-segment digit codes.
//   state_i       : current sequencer state
//   operand_a_i   : {A_hi, A_lo} BCD
//   operand_b_i   : {B_hi, B_lo} BCD
//   result_i      : latched result, four BCD digits, MSD first
//   result_neg_i  : latched result sign
//   disp3_o..0_o  : display codes (0-9 digit, 10 minus, 14 'E', 15 blank)
module calc_disp_map
    import calc_pkg::*;
(
    input  state_t      state_i,
    input  logic [7:0]  operand_a_i,
    input  logic [7:0]  operand_b_i,
    input  logic [15:0] result_i,
    input  logic        result_neg_i,
    output logic [3:0]  disp3_o,
    output logic [3:0]  disp2_o,
    output logic [3:0]  disp1_o,
    output logic [3:0]  disp0_o
);

    always_comb begin
        disp3_o = DSP_BLANK;
        disp2_o = DSP_BLANK;
        disp1_o = DSP_BLANK;
        disp0_o = DSP_BLANK;
        case (state_i)
            ST_A_HI: ;
            ST_A_LO: begin
                disp0_o = operand_a_i[7:4];
            end
            ST_OP: begin
                disp1_o = operand_a_i[7:4];
                disp0_o = operand_a_i[3:0];
            end
            ST_B_HI: begin
                disp3_o = operand_a_i[7:4];
                disp2_o = operand_a_i[3:0];
            end
            ST_B_LO: begin
                disp3_o = operand_a_i[7:4];
                disp2_o = operand_a_i[3:0];
                disp0_o = operand_b_i[7:4];
            end
            ST_WAIT_EQ, ST_CALC: begin
                disp3_o = operand_a_i[7:4];
                disp2_o = operand_a_i[3:0];
                disp1_o = operand_b_i[7:4];
                disp0_o = operand_b_i[3:0];
            end
            ST_SHOW: begin
                // The datapath never produces a 4-digit negative result, so
                // the sign takes over the most significant position.
                disp3_o = result_neg_i ? DSP_MINUS : result_i[15:12];
                disp2_o = result_i[11:8];
                disp1_o = result_i[7:4];
                disp0_o = result_i[3:0];
            end
            ST_ERR: begin
                disp3_o = DSP_E;
                disp2_o = DSP_E;
                disp1_o = DSP_E;
                disp0_o = DSP_E;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keyboard-driven sequencer for the two-operand BCD calculator.
// Collects A (2 digits), an operator and B (2 digits), waits for enter,
// starts the shared arithmetic datapath, waits for its done pulse under a
// timeout, and drives the four display digit codes for every phase.
//   clk, reset         : clock, synchronous active-high reset
//   key_valid/key_code : one-cycle decoded key event
//   alu_done           : one-cycle completion pulse, result_bcd/result_neg valid
//   operand_a/b, op_sel: operands and operation presented to the datapath
//   alu_start          : one-cycle start pulse (first cycle of CALC)
//   busy               : high while the datapath is running
//   disp3..disp0       : display codes
//   state_dbg          : current FSM state (calc_pkg::state_t encoding)
// Handshake: key_valid and alu_done are single-cycle pulses with no
// back-pressure; an event is consumed on the edge where it is high, and is
// ignored if the current state has no use for it.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 64
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        alu_done,
    input  logic [15:0] result_bcd,
    input  logic        result_neg,
    output logic [7:0]  operand_a,
    output logic [7:0]  operand_b,
    output logic [1:0]  op_sel,
    output logic        alu_start,
    output logic        busy,
    output logic [3:0]  disp3,
    output logic [3:0]  disp2,
    output logic [3:0]  disp1,
    output logic [3:0]  disp0,
    output logic [3:0]  state_dbg
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   res_q, res_d;
    logic          neg_q, neg_d;
    logic          start_q, start_d;

    logic key_digit;
    logic key_clr;

    assign key_digit = key_valid && is_digit(key_code);
    assign key_clr   = key_valid && (key_code == KEY_CLR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_A_HI;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            res_q   <= 16'h0000;
            neg_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        neg_d   = neg_q;
        start_d = 1'b0;

        // Clear overrides everything, including a coincident alu_done.
        if (key_clr) begin
            state_d = ST_A_HI;
            a_d     = 8'h00;
            b_d     = 8'h00;
            op_d    = OP_ADD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_A_HI: if (key_digit) begin
                    a_d     = {key_code, a_q[3:0]};
                    state_d = ST_A_LO;
                end
                ST_A_LO: if (key_digit) begin
                    a_d     = {a_q[7:4], key_code};
                    state_d = ST_OP;
                end
                ST_OP: if (key_valid) begin
                    if (key_code == KEY_ADD) begin
                        op_d    = OP_ADD;
                        state_d = ST_B_HI;
                    end else if (key_code == KEY_SUB) begin
                        op_d    = OP_SUB;
                        state_d = ST_B_HI;
                    end else if (key_code == KEY_MUL) begin
                        op_d    = OP_MUL;
                        state_d = ST_B_HI;
                    end
                end
                ST_B_HI: if (key_digit) begin
                    b_d     = {key_code, b_q[3:0]};
                    state_d = ST_B_LO;
                end
                ST_B_LO: if (key_digit) begin
                    b_d     = {b_q[7:4], key_code};
                    state_d = ST_WAIT_EQ;
                end
                ST_WAIT_EQ: if (key_valid && (key_code == KEY_EQ)) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
                ST_CALC: begin
                    // Done is checked first so it wins over a coincident timeout.
                    if (alu_done) begin
                        res_d   = result_bcd;
                        neg_d   = result_neg;
                        state_d = ST_SHOW;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_ERR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SHOW: if (key_digit) begin
                    a_d     = {key_code, 4'h0};
                    b_d     = 8'h00;
                    state_d = ST_A_LO;
                end
                ST_ERR: ;
                default: state_d = ST_A_HI;
            endcase
        end
    end

    assign operand_a = a_q;
    assign operand_b = b_q;
    assign op_sel    = op_q;
    assign alu_start = start_q;
    assign busy      = (state_q == ST_CALC);
    assign state_dbg = state_q;

    calc_disp_map u_disp_map (
        .state_i      (state_q),
        .operand_a_i  (a_q),
        .operand_b_i  (b_q),
        .result_i     (res_q),
        .result_neg_i (neg_q),
        .disp3_o      (disp3),
        .disp2_o      (disp2),
        .disp1_o      (disp1),
        .disp0_o      (disp0)
    );

endmodule

// File: tb/tb_calc_seq_ctrl.sv
module tb_calc_seq_ctrl;

  localparam int TO = 20;

  localparam logic [3:0] S_A_HI = 4'd0;
  localparam logic [3:0] S_A_LO = 4'd1;
  localparam logic [3:0] S_OP   = 4'd2;
  localparam logic [3:0] S_B_HI = 4'd3;
  localparam logic [3:0] S_B_LO = 4'd4;
  localparam logic [3:0] S_WEQ  = 4'd5;
  localparam logic [3:0] S_CALC = 4'd6;
  localparam logic [3:0] S_SHOW = 4'd7;
  localparam logic [3:0] S_ERR  = 4'd8;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_EQ  = 4'd13;
  localparam logic [3:0] K_CLR = 4'd14;
  localparam logic [3:0] K_IGN = 4'd15;

  typedef struct packed {
    logic [3:0]  key;
    logic [3:0]  exp_state;
    logic [15:0] exp_disp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        alu_done;
  logic [15:0] result_bcd;
  logic        result_neg;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic [1:0]  op_sel;
  logic        alu_start;
  logic        busy;
  logic [3:0]  disp3, disp2, disp1, disp0;
  logic [3:0]  state_dbg;
  logic [15:0] disp_all;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_starts = 0;

  // expected {operand_a, operand_b, op_sel} at each alu_start
  logic [17:0] exp_q[$];

  vec_t tbl1[11];
  vec_t tbl2[6];

  assign disp_all = {disp3, disp2, disp1, disp0};

  calc_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu_done   (alu_done),
    .result_bcd (result_bcd),
    .result_neg (result_neg),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .op_sel     (op_sel),
    .alu_start  (alu_start),
    .busy       (busy),
    .disp3      (disp3),
    .disp2      (disp2),
    .disp1      (disp1),
    .disp0      (disp0),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: all called at #1 after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    key_code  = K_IGN;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    press(v.key);
    check($sformatf("vec%0d_state", idx), {28'h0, state_dbg}, {28'h0, v.exp_state});
    check($sformatf("vec%0d_disp", idx), {16'h0, disp_all}, {16'h0, v.exp_disp});
  endtask

  task automatic enter_keys(input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2,
                            input logic [3:0] k3, input logic [3:0] k4);
    press(k0); press(k1); press(k2); press(k3); press(k4);
  endtask

  // called in the first CALC cycle; done arrives two cycles after alu_start
  task automatic finish_calc(input logic [15:0] r, input logic neg);
    step();
    step();
    alu_done   = 1'b1;
    result_bcd = r;
    result_neg = neg;
    step();
    alu_done   = 1'b0;
    result_bcd = 16'h0000;
    result_neg = 1'b0;
  endtask

  // scoreboard: compare operands at every alu_start against the queue
  always @(negedge clk) begin
    if (!reset && alu_start) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_start: got alu_start=1 required no start");
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("start_operands", {14'h0, operand_a, operand_b, op_sel}, {14'h0, e});
        n_checks++;
        if (busy === 1'b1) n_pass++;
        else begin
          n_fail++;
          $display("FAIL start_busy: got %0b required 1", busy);
        end
      end
    end
  end

  initial begin
    int ncyc;
    int starts_before;

    // expected-value tables
    tbl1[0]  = '{K_ADD, S_A_HI, 16'hFFFF};  // operator in A_HI ignored
    tbl1[1]  = '{4'd1,  S_A_LO, 16'hFFF1};
    tbl1[2]  = '{4'd2,  S_OP,   16'hFF12};
    tbl1[3]  = '{4'd5,  S_OP,   16'hFF12};  // digit in OP ignored
    tbl1[4]  = '{K_ADD, S_B_HI, 16'h12FF};
    tbl1[5]  = '{K_EQ,  S_B_HI, 16'h12FF};  // enter in B_HI ignored
    tbl1[6]  = '{4'd3,  S_B_LO, 16'h12F3};
    tbl1[7]  = '{K_EQ,  S_B_LO, 16'h12F3};  // enter in B_LO ignored
    tbl1[8]  = '{4'd4,  S_WEQ,  16'h1234};
    tbl1[9]  = '{4'd9,  S_WEQ,  16'h1234};  // digit in WAIT_EQ ignored
    tbl1[10] = '{K_IGN, S_WEQ,  16'h1234};
    tbl2[0]  = '{K_CLR, S_A_HI, 16'hFFFF};
    tbl2[1]  = '{4'd0,  S_A_LO, 16'hFFF0};
    tbl2[2]  = '{4'd5,  S_OP,   16'hFF05};
    tbl2[3]  = '{K_SUB, S_B_HI, 16'h05FF};
    tbl2[4]  = '{4'd0,  S_B_LO, 16'h05F0};
    tbl2[5]  = '{4'd9,  S_WEQ,  16'h0509};

    reset      = 1'b1;
    key_valid  = 1'b0;
    key_code   = K_IGN;
    alu_done   = 1'b0;
    result_bcd = 16'h0000;
    result_neg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    check("rst_state", {28'h0, state_dbg}, {28'h0, S_A_HI});
    check("rst_disp", {16'h0, disp_all}, 32'hFFFF);
    check("rst_opab", {16'h0, operand_a, operand_b}, 32'h0);
    check("rst_ctl", {29'h0, op_sel, alu_start}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);

    // addition 12 + 34 with ignored keys interleaved
    for (int i = 0; i < 11; i++) run_vec(tbl1[i], i);
    exp_q.push_back({8'h12, 8'h34, 2'd0});
    press(K_EQ);
    check("add_calc_state", {28'h0, state_dbg}, {28'h0, S_CALC});
    check("add_start_first", {31'h0, alu_start}, 32'h1);
    finish_calc(16'h0046, 1'b0);
    check("add_show_state", {28'h0, state_dbg}, {28'h0, S_SHOW});
    check("add_show_disp", {16'h0, disp_all}, 32'h0046);
    check("add_operands", {14'h0, operand_a, operand_b, op_sel}, {14'h0, 8'h12, 8'h34, 2'd0});
    check("add_one_start", n_starts, 1);

    // subtraction 05 - 09 with negative result
    for (int i = 0; i < 6; i++) run_vec(tbl2[i], 20 + i);
    exp_q.push_back({8'h05, 8'h09, 2'd1});
    press(K_EQ);
    finish_calc(16'h0004, 1'b1);
    check("sub_show_disp", {16'h0, disp_all}, 32'hA004);
    check("sub_opsel", {30'h0, op_sel}, 32'h1);

    // timeout: no alu_done at all
    press(K_CLR);
    enter_keys(4'd9, 4'd9, K_MUL, 4'd9, 4'd8);
    exp_q.push_back({8'h99, 8'h98, 2'd2});
    press(K_EQ);
    ncyc = 0;
    while (state_dbg == S_CALC && ncyc < 10 * TO) begin
      step();
      ncyc++;
    end
    check("to_cycles", ncyc, TO);
    check("to_state", {28'h0, state_dbg}, {28'h0, S_ERR});
    check("to_disp", {16'h0, disp_all}, 32'hEEEE);
    press(4'd3);
    check("err_digit_ignored", {28'h0, state_dbg}, {28'h0, S_ERR});
    press(K_CLR);
    check("err_clr_state", {28'h0, state_dbg}, {28'h0, S_A_HI});
    check("err_clr_disp", {16'h0, disp_all}, 32'hFFFF);
    check("err_clr_regs", {14'h0, operand_a, operand_b, op_sel}, 32'h0);

    // clear and alu_done in the same CALC cycle
    enter_keys(4'd1, 4'd2, K_ADD, 4'd3, 4'd4);
    exp_q.push_back({8'h12, 8'h34, 2'd0});
    press(K_EQ);
    step();
    key_valid  = 1'b1;
    key_code   = K_CLR;
    alu_done   = 1'b1;
    result_bcd = 16'h0777;
    step();
    key_valid  = 1'b0;
    key_code   = K_IGN;
    alu_done   = 1'b0;
    result_bcd = 16'h0000;
    check("clrdone_state", {28'h0, state_dbg}, {28'h0, S_A_HI});
    check("clrdone_disp", {16'h0, disp_all}, 32'hFFFF);
    check("clrdone_regs", {16'h0, operand_a, operand_b}, 32'h0);

    // SHOW then a new digit starts a fresh entry
    enter_keys(4'd2, 4'd1, K_MUL, 4'd0, 4'd3);
    exp_q.push_back({8'h21, 8'h03, 2'd2});
    press(K_EQ);
    finish_calc(16'h0063, 1'b0);
    check("mul_show_disp", {16'h0, disp_all}, 32'h0063);
    press(4'd7);
    check("show_digit_state", {28'h0, state_dbg}, {28'h0, S_A_LO});
    check("show_digit_disp", {16'h0, disp_all}, 32'hFFF7);
    check("show_digit_regs", {16'h0, operand_a, operand_b}, 32'h7000);

    // alu_done outside CALC is ignored
    alu_done   = 1'b1;
    result_bcd = 16'h9999;
    step();
    alu_done   = 1'b0;
    result_bcd = 16'h0000;
    check("stray_done_state", {28'h0, state_dbg}, {28'h0, S_A_LO});
    check("stray_done_disp", {16'h0, disp_all}, 32'hFFF7);

    // reset in the middle of CALC
    press(4'd5); press(K_SUB); press(4'd1); press(4'd1);
    exp_q.push_back({8'h75, 8'h11, 2'd1});
    press(K_EQ);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_state", {28'h0, state_dbg}, {28'h0, S_A_HI});
    check("midrst_disp", {16'h0, disp_all}, 32'hFFFF);
    check("midrst_regs", {14'h0, operand_a, operand_b, op_sel}, 32'h0);
    check("midrst_ctl", {30'h0, alu_start, busy}, 32'h0);
    starts_before = n_starts;
    repeat (3 * TO) step();
    check("midrst_no_restart", n_starts, starts_before);
    check("queue_empty", exp_q.size(), 0);
    check("total_starts", n_starts, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Keyboard-driven sequencer for the two-operand decimal calculator. It consumes decoded key events and collects two 2-digit BCD operands and an operator. It then starts the shared arithmetic datapath (adder/subtractor/multiplier), waits for completion with a timeout, and drives the four seven-segment digit codes for every phase. It sits between the PS/2 keyboard decoder and the display multiplexer.

## Interface
Parameters:
- TIMEOUT, 64: max cycles from alu_start to alu_done before the error state is entered.

Ports:
- clk  in  1  system clock; the block's single clock.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle pulse; key_code is valid this cycle.
- key_code  in  4  0-9 digit, 10 '+', 11 '-', 12 '*', 13 enter, 14 clear, 15 ignored.
- alu_done  in  1  one-cycle pulse from datapath; result valid this cycle.
- result_bcd  in  16  four BCD digits of the result, MSD first.
- result_neg  in  1  result is negative (subtraction only).
- operand_a  out  8  {A_hi, A_lo} BCD.
- operand_b  out  8  {B_hi, B_lo} BCD.
- op_sel  out  2  0 add, 1 sub, 2 mul.
- alu_start  out  1  one-cycle start pulse.
- busy  out  1  high in CALC.
- disp3..disp0  out  4 each  display codes: 0-9 digit, 10 minus, 14 'E', 15 blank.

## Operation
- States: A_HI, A_LO, OP, B_HI, B_LO, WAIT_EQ, CALC, SHOW, ERR.
- A_HI: digit d -> A_hi=d, go to A_LO. A_LO: digit -> A_lo, go to OP.
- OP: '+', '-' or '*' -> op_sel = 0, 1 or 2, go to B_HI.
- B_HI: digit -> B_hi, go to B_LO. B_LO: digit -> B_lo, go to WAIT_EQ.
- WAIT_EQ: enter -> go to CALC, pulse alu_start. Only valid keys listed advance; all others are ignored.
- CALC: wait for alu_done. On done, latch result_bcd/result_neg and go to SHOW. When the timeout counter reaches TIMEOUT, go to ERR.
- SHOW: digit d -> clear operands, A_hi=d, go to A_LO. Other keys are ignored.
- ERR: only clear or reset exits.
- Clear (14) in any state: zero operands, op_sel=0, counter=0, go to A_HI.
- Display per state (disp3..disp0; B = blank):
  - A_HI: B B B B.
  - A_LO: B B B A_hi.
  - OP: B B A_hi A_lo.
  - B_HI: A_hi A_lo B B.
  - B_LO: A_hi A_lo B B_hi.
  - WAIT_EQ and CALC: A_hi A_lo B_hi B_lo.
  - SHOW: latched result digits, with disp3 forced to 10 when latched neg=1.
  - ERR: 14 14 14 14.

## Timing
- Reset values: state A_HI, operands 0, op_sel 0, alu_start 0, busy 0, latched result 0, disp* = 15.
- State and registers update on the clk edge at which key_valid=1. Displays are combinational from registers and update in the same cycle as the new state.
- alu_start is high exactly the first cycle in CALC, registered on the edge that sampled enter. operand_a, operand_b and op_sel stay stable throughout CALC.
- The timeout counter clears on CALC entry and increments each CALC cycle. ERR is entered on the edge where the count equals TIMEOUT-1 with no alu_done.
- If alu_done and timeout occur in the same cycle, done wins.
- If key_valid with clear and alu_done occur in the same cycle, clear wins and the result is discarded. Non-clear keys in CALC are ignored.
- An alu_done pulse outside CALC is ignored.
- A reset asserted mid-CALC aborts the operation; no further alu_start is issued.

## Structure
- Shared package calc_pkg holds:
  - state encoding;
  - key codes (KEY_ADD=10, KEY_SUB=11, KEY_MUL=12, KEY_EQ=13, KEY_CLR=14);
  - display codes (DSP_MINUS=10, DSP_E=14, DSP_BLANK=15);
  - op_sel encoding.
- One natural sub-module, calc_disp_map: combinational state/operand/result-to-disp mapping.
- The FSM, operand registers and timeout counter live in the top level.

## Test plan
- Keys 1,2,'+',3,4,enter; alu_done two cycles after alu_start with result_bcd=0x0046 -> operand_a=0x12, operand_b=0x34, op_sel=0, one alu_start pulse, SHOW displays 0 0 4 6.
- Keys 0,5,'-',0,9,enter; done with result_bcd=0x0004, neg=1 -> disp = 10 0 0 4.
- Full entry then enter with no alu_done -> ERR after exactly TIMEOUT cycles; disp = 14 14 14 14; clear -> A_HI, all blank.
- Keys '+' in A_HI, digit in OP, enter in B_LO -> all ignored; state and display unchanged.
- In CALC, clear and alu_done in the same cycle -> A_HI, operands 0, result not shown.
- In SHOW, digit 7 -> A_LO, display B B B 7, operand_b=0; reset mid-CALC -> all reset values the next cycle.
